// File: rtl/ddram_pkg.sv
// ddram_pkg: shared types and constants for the DD_RAM request sequencer.
//   state_t       - sequencer states
//   ADDR_W_DEF    - default word-select width (4 words)
//   DATA_W_DEF    - default lane width
//   MEM_RW_IDLE   - RW level while no load/read phase is active
//   MEM_SEL_IDLE  - select value while no transaction is active
package ddram_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WLOAD = 3'd1,
      WHOLD = 3'd2,
      RLOAD = 3'd3,
      RESP  = 3'd4
   } state_t;

   localparam int   ADDR_W_DEF   = 2;
   localparam int   DATA_W_DEF   = 4;
   localparam logic MEM_RW_IDLE  = 1'b1;
   localparam int   MEM_SEL_IDLE = 0;

endpackage

// File: rtl/ddram_phase_cnt.sv
// ddram_phase_cnt: 4-bit loadable down-counter timing the WHOLD/RLOAD phases.
//   clk, rst   - clock, asynchronous active-low reset
//   load       - load load_val this cycle (takes priority over counting)
//   load_val   - phase length minus one
//   cnt        - current count
//   zero       - count has reached zero (last cycle of the phase)
module ddram_phase_cnt
   import ddram_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_val,
   output logic [3:0] cnt,
   output logic       zero
);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   // Saturates at zero so an overlong phase can never wrap to 15.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/ddram_access_ctrl.sv
// ddram_access_ctrl: sequences single-beat write/read requests into the
// RW/select/data phases of the dual-lane DD_RAM block and returns read data.
//   req_*       - request handshake and write payload (captured at acceptance)
//   rsp_*       - read response handshake and data
//   wr_done     - one-cycle pulse on the last WHOLD cycle
//   mem_*       - memory block RW/select/data drive and read data return
// All outputs are registered; next values are decoded from the next state.
//
// state | meaning
// IDLE  | idle memory drive, req_ready=1, waiting for a request
// WLOAD | one cycle RW=0 with write address/data
// WHOLD | WR_HOLD cycles RW=1 holding address/data, wr_done on last
// RLOAD | RD_WAIT cycles RW=0 with read address, sample data on last
// RESP  | rsp_valid=1 until rsp_ready
module ddram_access_ctrl
   import ddram_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int WR_HOLD = 4,
   parameter int RD_WAIT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data_a,
   input  logic [DATA_W-1:0] req_data_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data_a,
   output logic [DATA_W-1:0] rsp_data_b,
   output logic              wr_done,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_sel,
   output logic [DATA_W-1:0] mem_din_a,
   output logic [DATA_W-1:0] mem_din_b,
   input  logic [DATA_W-1:0] mem_dout_a,
   input  logic [DATA_W-1:0] mem_dout_b
);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_a_q, data_a_d;
   logic [DATA_W-1:0]   data_b_q, data_b_d;
   logic                req_ready_q, req_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_data_a_q, rsp_data_a_d;
   logic [DATA_W-1:0]   rsp_data_b_q, rsp_data_b_d;
   logic                wr_done_q, wr_done_d;
   logic                mem_rw_q, mem_rw_d;
   logic [ADDR_W-1:0]   mem_sel_q, mem_sel_d;
   logic [DATA_W-1:0]   mem_din_a_q, mem_din_a_d;
   logic [DATA_W-1:0]   mem_din_b_q, mem_din_b_d;

   logic                accept;
   logic                cnt_load;
   logic [3:0]          cnt_load_val;
   logic [3:0]          cnt;
   logic                cnt_zero;

   ddram_phase_cnt u_phase_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .cnt      (cnt),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      data_a_d     = data_a_q;
      data_b_d     = data_b_q;
      rsp_data_a_d = rsp_data_a_q;
      rsp_data_b_d = rsp_data_b_q;
      accept       = (state_q == IDLE) && req_valid && req_ready_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d   = req_addr;
               data_a_d = req_data_a;
               data_b_d = req_data_b;
               state_d  = req_write ? WLOAD : RLOAD;
            end
         end
         WLOAD: state_d = WHOLD;
         WHOLD: begin
            if (cnt_zero) state_d = IDLE;
         end
         RLOAD: begin
            if (cnt_zero) begin
               rsp_data_a_d = mem_dout_a;
               rsp_data_b_d = mem_dout_b;
               state_d      = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      cnt_load     = (state_d != state_q) && ((state_d == WHOLD) || (state_d == RLOAD));
      cnt_load_val = (state_d == WHOLD) ? 4'(WR_HOLD - 1) : 4'(RD_WAIT - 1);

      // Outputs are registered, so decode them from the state being entered.
      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
      mem_rw_d    = ((state_d == WLOAD) || (state_d == RLOAD)) ? 1'b0 : MEM_RW_IDLE;
      mem_sel_d   = ADDR_W'(MEM_SEL_IDLE);
      mem_din_a_d = '0;
      mem_din_b_d = '0;
      if ((state_d == WLOAD) || (state_d == WHOLD) || (state_d == RLOAD)) begin
         mem_sel_d = addr_d;
      end
      if ((state_d == WLOAD) || (state_d == WHOLD)) begin
         mem_din_a_d = data_a_d;
         mem_din_b_d = data_b_d;
      end
      // Pulse lands on the cycle whose count is zero: one cycle before it
      // the count is 1, or WHOLD is a single cycle entered from WLOAD.
      wr_done_d = ((state_q == WHOLD) && (cnt == 4'd1)) ||
                  ((state_q == WLOAD) && (WR_HOLD == 1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         data_a_q     <= '0;
         data_b_q     <= '0;
         req_ready_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_data_a_q <= '0;
         rsp_data_b_q <= '0;
         wr_done_q    <= 1'b0;
         mem_rw_q     <= MEM_RW_IDLE;
         mem_sel_q    <= ADDR_W'(MEM_SEL_IDLE);
         mem_din_a_q  <= '0;
         mem_din_b_q  <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         data_a_q     <= data_a_d;
         data_b_q     <= data_b_d;
         req_ready_q  <= req_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_a_q <= rsp_data_a_d;
         rsp_data_b_q <= rsp_data_b_d;
         wr_done_q    <= wr_done_d;
         mem_rw_q     <= mem_rw_d;
         mem_sel_q    <= mem_sel_d;
         mem_din_a_q  <= mem_din_a_d;
         mem_din_b_q  <= mem_din_b_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data_a = rsp_data_a_q;
   assign rsp_data_b = rsp_data_b_q;
   assign wr_done    = wr_done_q;
   assign mem_rw     = mem_rw_q;
   assign mem_sel    = mem_sel_q;
   assign mem_din_a  = mem_din_a_q;
   assign mem_din_b  = mem_din_b_q;

endmodule
